// File: rtl/minterm_sweep_engine.sv
// Programmable N-variable Boolean function unit with a registered evaluator and a
// handshaked sweep that streams minterm or maxterm indices and counts them.
module minterm_sweep_engine #(
  parameter int                      N_VARS   = 4,
  parameter logic [(1<<N_VARS)-1:0]  TT_RESET = 16'hDF03
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tt_load,
  input  logic [(1<<N_VARS)-1:0]  tt_data,
  input  logic [N_VARS-1:0]       eval_in,
  output logic                    f_out,
  input  logic                    start,
  input  logic                    mode,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [N_VARS-1:0]       m_index,
  output logic                    busy,
  output logic                    done,
  output logic [N_VARS:0]         count
);

  typedef enum logic [1:0] {IDLE, SWEEP, FIN} state_t;

  state_t                   state, state_next;
  logic [(1<<N_VARS)-1:0]   table_q;
  logic [N_VARS-1:0]        idx;
  logic                     mode_q;
  logic                     hit;
  logic                     advance;
  logic                     last_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // An index is resolved either by skipping it (no hit) or by a completed handshake.
  always_comb begin
    state_next = state;
    hit        = table_q[idx] ^ mode_q;
    last_idx   = &idx;
    advance    = 1'b0;
    m_valid    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = SWEEP;
      end
      SWEEP: begin
        busy    = 1'b1;
        m_valid = hit;
        advance = !hit || m_ready;
        if (advance && last_idx) state_next = FIN;
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Table writes and sweep setup are only honoured while idle; idx saturates at the
  // last index so a finished sweep never wraps back into the table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      table_q <= TT_RESET;
      idx     <= '0;
      mode_q  <= 1'b0;
      count   <= '0;
      f_out   <= 1'b0;
    end else begin
      f_out <= table_q[eval_in];
      if (state == IDLE) begin
        if (tt_load) table_q <= tt_data;
        if (start) begin
          idx    <= '0;
          count  <= '0;
          mode_q <= mode;
        end
      end else if (advance) begin
        if (hit)       count <= count + 1'b1;
        if (!last_idx) idx   <= idx + 1'b1;
      end
    end
  end

  assign m_index = idx;

endmodule

// File: tb/tb_minterm_sweep_engine.sv
// Directed bench for minterm_sweep_engine: table-driven sweeps plus hand-written
// sequences for backpressure, mid-sweep reset, evaluation and busy-time input masking.
module tb_minterm_sweep_engine;

  logic        clk;
  logic        rst_n;
  logic        tt_load;
  logic [15:0] tt_data;
  logic [3:0]  eval_in;
  logic        f_out;
  logic        start;
  logic        mode;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  m_index;
  logic        busy;
  logic        done;
  logic [4:0]  count;

  int checks;
  int failures;

  minterm_sweep_engine #(.N_VARS(4), .TT_RESET(16'hDF03)) dut (
    .clk(clk), .rst_n(rst_n), .tt_load(tt_load), .tt_data(tt_data),
    .eval_in(eval_in), .f_out(f_out), .start(start), .mode(mode),
    .m_valid(m_valid), .m_ready(m_ready), .m_index(m_index),
    .busy(busy), .done(done), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          load_kind;
    logic [15:0] tt;
    logic        mode;
    logic [15:0] exp_mask;
    int          exp_count;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Runs one full sweep with m_ready held high; load_kind 1 = load beforehand, 2 = load with start.
  task automatic applyStimulus(input int load_kind, input logic [15:0] tt, input logic m,
                               output int cycles, output logic [15:0] mask,
                               output logic order_ok, output logic got_done);
    int last;
    m_ready = 1'b1;
    if (load_kind == 1) begin
      @(negedge clk);
      tt_load = 1'b1; tt_data = tt;
      @(negedge clk);
      tt_load = 1'b0;
    end
    @(negedge clk);
    start = 1'b1; mode = m;
    if (load_kind == 2) begin tt_load = 1'b1; tt_data = tt; end
    @(negedge clk);
    start = 1'b0; tt_load = 1'b0;
    cycles = 0; mask = '0; order_ok = 1'b1; got_done = 1'b0; last = -1;
    for (int k = 0; k < 64; k++) begin
      if (done) begin got_done = 1'b1; break; end
      if (busy) cycles++;
      if (m_valid && m_ready) begin
        if (int'(m_index) <= last) order_ok = 1'b0;
        last = int'(m_index);
        mask[m_index] = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int          cycles;
    logic [15:0] mask;
    logic        order_ok;
    logic        got_done;
    int          n_min;
    int          n_max;
    logic        seen;

    checks = 0; failures = 0;
    rst_n = 1'b0; tt_load = 1'b0; tt_data = '0; eval_in = '0;
    start = 1'b0; mode = 1'b0; m_ready = 1'b0;

    vecs[0] = '{0, 16'hDF03, 1'b0, 16'hDF03, 9};
    vecs[1] = '{0, 16'hDF03, 1'b1, 16'h20FC, 7};
    vecs[2] = '{1, 16'h0000, 1'b0, 16'h0000, 0};
    vecs[3] = '{1, 16'hFFFF, 1'b0, 16'hFFFF, 16};
    vecs[4] = '{0, 16'hFFFF, 1'b1, 16'h0000, 0};
    vecs[5] = '{2, 16'hA5A5, 1'b0, 16'hA5A5, 8};
    vecs[6] = '{0, 16'hA5A5, 1'b1, 16'h5A5A, 8};

    #12;
    checkOutput("reset f_out",   32'(f_out),   32'd0);
    checkOutput("reset m_valid", 32'(m_valid), 32'd0);
    checkOutput("reset m_index", 32'(m_index), 32'd0);
    checkOutput("reset busy",    32'(busy),    32'd0);
    checkOutput("reset done",    32'(done),    32'd0);
    checkOutput("reset count",   32'(count),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    n_min = 0; n_max = 0;
    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].load_kind, vecs[v].tt, vecs[v].mode, cycles, mask, order_ok, got_done);
      checkOutput($sformatf("vec%0d done seen", v),    32'(got_done), 32'd1);
      checkOutput($sformatf("vec%0d sweep cycles", v), 32'(cycles),   32'd16);
      checkOutput($sformatf("vec%0d index mask", v),   32'(mask),     32'(vecs[v].exp_mask));
      checkOutput($sformatf("vec%0d order", v),        32'(order_ok), 32'd1);
      checkOutput($sformatf("vec%0d count", v),        32'(count),    32'(vecs[v].exp_count));
      checkOutput($sformatf("vec%0d busy at done", v), 32'(busy),     32'd0);
      @(negedge clk);
      checkOutput($sformatf("vec%0d done pulse", v),   32'(done),     32'd0);
      checkOutput($sformatf("vec%0d count hold", v),   32'(count),    32'(vecs[v].exp_count));
      if (v == 0) n_min = int'(count);
      if (v == 1) n_max = int'(count);
    end
    checkOutput("minterm+maxterm sum", 32'(n_min + n_max), 32'd16);

    // Mid-sweep reset with a non-default table: abort after index 9 is accepted.
    @(negedge clk);
    tt_load = 1'b1; tt_data = 16'h0F0F;
    @(negedge clk);
    tt_load = 1'b0; start = 1'b1; mode = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (m_valid && m_index == 4'd9) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checkOutput("abort reached index 9", 32'(seen), 32'd1);
    @(negedge clk);
    checkOutput("abort count before reset", 32'(count), 32'd6);
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy",    32'(busy),    32'd0);
    checkOutput("abort m_valid", 32'(m_valid), 32'd0);
    checkOutput("abort count",   32'(count),   32'd0);
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checkOutput("abort no done", 32'(seen), 32'd0);
    eval_in = 4'd2;
    @(negedge clk);
    checkOutput("table reset eval 2", 32'(f_out), 32'd0);
    eval_in = 4'd12;
    @(negedge clk);
    checkOutput("table reset eval 12", 32'(f_out), 32'd1);

    // Backpressure on index 8: hold for three cycles, then accept.
    m_ready = 1'b1; start = 1'b1; mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (m_valid && m_index == 4'd8) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checkOutput("bp reached index 8", 32'(seen), 32'd1);
    m_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("bp hold%0d valid", k), 32'(m_valid), 32'd1);
      checkOutput($sformatf("bp hold%0d index", k), 32'(m_index), 32'd8);
      checkOutput($sformatf("bp hold%0d count", k), 32'(count),   32'd2);
    end
    m_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp count after accept", 32'(count),   32'd3);
    checkOutput("bp next index",         32'(m_index), 32'd9);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checkOutput("bp done seen", 32'(seen),  32'd1);
    checkOutput("bp final count", 32'(count), 32'd9);

    // Live evaluation on the default table.
    @(negedge clk);
    eval_in = 4'b1101;
    @(negedge clk);
    checkOutput("eval 1101", 32'(f_out), 32'd0);
    eval_in = 4'b1110;
    @(negedge clk);
    checkOutput("eval 1110", 32'(f_out), 32'd1);

    // start and tt_load while busy must be ignored.
    start = 1'b1; mode = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0; seen = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (done) begin seen = 1'b1; break; end
      if (busy) cycles++;
      if (k == 5) begin start = 1'b1; mode = 1'b1; tt_load = 1'b1; tt_data = 16'h0000; end
      else begin start = 1'b0; tt_load = 1'b0; end
      @(negedge clk);
    end
    start = 1'b0; tt_load = 1'b0;
    checkOutput("busy ignore done seen", 32'(seen),   32'd1);
    checkOutput("busy ignore cycles",    32'(cycles), 32'd16);
    checkOutput("busy ignore count",     32'(count),  32'd9);
    eval_in = 4'd0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("busy ignore table", 32'(f_out), 32'd1);
    checkOutput("busy ignore idle",  32'(busy),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
